// File: rtl/pipelined_ripple_adder.sv
// Segmented ripple add/subtract with one register stage per SEG-bit segment,
// skewed operands in and deskewed result out, valid/ready stream handshake.
module pipelined_ripple_adder #(
  parameter int WIDTH = 24,
  parameter int SEG   = 4
) (
  input  logic             ck,
  input  logic             rn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             co,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  generate
    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
      $error("pipelined_ripple_adder: WIDTH must be a positive multiple of SEG");
    end
  endgenerate

  // Operands shift right by SEG per stage so the next segment to add is
  // always at bit 0; the result shifts right with each new segment entering
  // at the top, so after STAGES stages it is aligned.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;
  logic             en_q;
  logic             adv;

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             src_c [STAGES];
  logic             src_v [STAGES];
  logic [SEG:0]     seg_r [STAGES];
  logic             ovf_d;

  assign adv       = !v_q[STAGES-1] || out_ready;
  assign in_ready  = en_q && adv;
  assign out_valid = v_q[STAGES-1];
  assign SUM       = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign ovf       = ovf_q;

  always_comb begin
    src_a[0] = A;
    src_b[0] = B ^ {WIDTH{sub}};
    src_c[0] = ci ^ sub;
    src_v[0] = in_valid && in_ready;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = v_q[k-1];
      src_s[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_r[k] = {1'b0, src_a[k][SEG-1:0]} + {1'b0, src_b[k][SEG-1:0]}
               + (SEG+1)'(src_c[k]);
      s_d[k]   = (src_s[k] >> SEG) | (WIDTH'(seg_r[k][SEG-1:0]) << (WIDTH - SEG));
    end
    // a^b^sum at the MSB recovers the carry into it
    ovf_d = src_a[STAGES-1][SEG-1] ^ src_b[STAGES-1][SEG-1]
          ^ seg_r[STAGES-1][SEG-1] ^ seg_r[STAGES-1][SEG];
  end

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else begin
      en_q <= 1'b1;
      if (adv) begin
        for (int k = 0; k < STAGES; k++) begin
          v_q[k] <= src_v[k];
          // bubbles leave data untouched so outputs change only on real results
          if (src_v[k]) begin
            a_q[k] <= src_a[k] >> SEG;
            b_q[k] <= src_b[k] >> SEG;
            s_q[k] <= s_d[k];
            c_q[k] <= seg_r[k][SEG];
          end
        end
        if (src_v[STAGES-1]) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and random checks of pipelined_ripple_adder in three geometries:
// 24/4 (6 stages), 8/8 (1 stage) and 32/8 (4 stages).
module tb_pipelined_ripple_adder;

  logic ck, rn;

  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [23:0] a24, b24, sum24;

  logic        iv8, ir8, ov8, co8, of8, iv32, ir32, ov32, co32, of32;
  logic        sw_ci, sw_sub, sw_ordy;
  logic [7:0]  a8, b8, s8;
  logic [31:0] a32, b32, s32;

  pipelined_ripple_adder #(.WIDTH(24), .SEG(4)) u_dut (
    .ck(ck), .rn(rn), .in_valid(in_valid), .in_ready(in_ready),
    .A(a24), .B(b24), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .SUM(sum24), .co(co), .ovf(ovf)
  );

  pipelined_ripple_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
    .ck(ck), .rn(rn), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .ci(sw_ci), .sub(sw_sub),
    .out_valid(ov8), .out_ready(sw_ordy),
    .SUM(s8), .co(co8), .ovf(of8)
  );

  pipelined_ripple_adder #(.WIDTH(32), .SEG(8)) u_dut32 (
    .ck(ck), .rn(rn), .in_valid(iv32), .in_ready(ir32),
    .A(a32), .B(b32), .ci(sw_ci), .sub(sw_sub),
    .out_valid(ov32), .out_ready(sw_ordy),
    .SUM(s32), .co(co32), .ovf(of32)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        ci;
    logic        sub;
    logic [23:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    int          cyc;
  } exp_t;

  // Independent reference: sign-based overflow rule, width-masked arithmetic
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s, input int cyc);
    exp_t        e;
    logic [31:0] mask, am, bx;
    logic [32:0] full;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am    = a & mask;
    bx    = (b ^ {32{s}}) & mask;
    full  = {1'b0, am} + {1'b0, bx} + {32'b0, c ^ s};
    e.sum = full[31:0] & mask;
    e.co  = full[w];
    e.ovf = (am[w-1] == bx[w-1]) && (e.sum[w-1] != am[w-1]);
    e.cyc = cyc;
    return e;
  endfunction

  vec_t vt [10];
  exp_t q8 [$];
  exp_t q32 [$];

  initial begin
    int   lat, rx, issued, hold_left, n_bad;
    bit   hold_done;
    exp_t e;

    vt[0] = '{24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
    vt[1] = '{24'h000FFF, 24'h000000, 1'b1, 1'b0, 24'h001000, 1'b0, 1'b0};
    vt[2] = '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1};
    vt[3] = '{24'h000005, 24'h000007, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
    vt[4] = '{24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1};
    vt[5] = '{24'h000009, 24'h000004, 1'b1, 1'b1, 24'h000004, 1'b1, 1'b0};
    vt[6] = '{24'h000000, 24'h000000, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    vt[7] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1};
    vt[8] = '{24'h123456, 24'h654321, 1'b0, 1'b0, 24'h777777, 1'b0, 1'b0};
    vt[9] = '{24'h000000, 24'h000000, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b0};

    rn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a24 = '0; b24 = '0; ci = 1'b0; sub = 1'b0;
    iv8 = 1'b0; iv32 = 1'b0; sw_ordy = 1'b1; sw_ci = 1'b0; sw_sub = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;

    // Reset state
    tick(); tick();
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_outputs", {38'b0, sum24, co, ovf}, 64'd0);
    rn = 1'b1;
    tick();
    check("release_in_ready", {63'b0, in_ready}, 64'd1);

    // Directed single transfers: latency and result
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a24 = vt[i].a; b24 = vt[i].b; ci = vt[i].ci; sub = vt[i].sub;
      #1;
      check($sformatf("vec%0d_in_ready", i), {63'b0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
        if (out_valid) begin
          lat = n;
          break;
        end
        tick();
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd6);
      check($sformatf("vec%0d_result", i), {38'b0, sum24, co, ovf},
            {38'b0, vt[i].sum, vt[i].co, vt[i].ovf});
      tick();
    end

    // Streaming with a 3-cycle backpressure hold after the first result
    rx = 0; issued = 0; hold_left = 0; hold_done = 1'b0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      if (issued < 8) begin
        in_valid = 1'b1; a24 = 24'(issued); b24 = 24'(issued * 'h100); ci = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && !hold_done) begin
        hold_done = 1'b1;
        hold_left = 3;
      end
      out_ready = (hold_left == 0);
      #1;
      if (in_valid && in_ready) issued++;
      if (hold_left > 0) begin
        check($sformatf("hold%0d_in_ready", hold_left), {63'b0, in_ready}, 64'd0);
        check($sformatf("hold%0d_output", hold_left), {39'b0, out_valid, sum24},
              {39'b0, 1'b1, 24'(rx * 'h101)});
        hold_left--;
      end else if (out_valid) begin
        check($sformatf("stream%0d_result", rx), {38'b0, sum24, co, ovf},
              {38'b0, 24'(rx * 'h101), 1'b0, 1'b0});
        rx++;
      end
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    check("stream_count", 64'(rx), 64'd8);
    n_bad = 0;
    for (int n = 0; n < 8; n++) begin
      if (out_valid) n_bad++;
      tick();
    end
    check("stream_no_duplicates", 64'(n_bad), 64'd0);

    // Asynchronous reset with a full pipeline
    in_valid = 1'b1; a24 = 24'h111111; b24 = 24'h222222; ci = 1'b0; sub = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    check("prefill_result", {39'b0, out_valid, sum24}, {39'b0, 1'b1, 24'h333333});
    #3;
    rn = 1'b0;
    #1;
    check("async_reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("async_reset_outputs", {38'b0, sum24, co, ovf}, 64'd0);
    in_valid = 1'b0;
    tick();
    #2;
    rn = 1'b1;
    tick();
    check("post_reset_in_ready", {63'b0, in_ready}, 64'd1);
    n_bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) n_bad++;
      tick();
    end
    check("post_reset_no_stale", 64'(n_bad), 64'd0);

    // Random streaming on the 1-stage and 4-stage geometries
    for (int cyc = 0; cyc < 10020; cyc++) begin
      if (cyc < 10000) begin
        iv8    = ($urandom_range(0, 9) != 0);
        a32    = $urandom;
        b32    = $urandom;
        sw_ci  = 1'($urandom_range(0, 1));
        sw_sub = 1'($urandom_range(0, 1));
      end else begin
        iv8 = 1'b0;
      end
      iv32 = iv8;
      a8   = a32[7:0];
      b8   = b32[7:0];
      #1;
      if (iv8 && ir8)   q8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, sw_ci, sw_sub, cyc));
      if (iv32 && ir32) q32.push_back(model(32, a32, b32, sw_ci, sw_sub, cyc));
      if (ov8) begin
        check("sw8_pending", {63'b0, q8.size() != 0}, 64'd1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          check("sw8_latency", 64'(cyc - e.cyc), 64'd1);
          check("sw8_result", {54'b0, of8, co8, s8}, {54'b0, e.ovf, e.co, e.sum[7:0]});
        end
      end
      if (ov32) begin
        check("sw32_pending", {63'b0, q32.size() != 0}, 64'd1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          check("sw32_latency", 64'(cyc - e.cyc), 64'd4);
          check("sw32_result", {30'b0, of32, co32, s32}, {30'b0, e.ovf, e.co, e.sum});
        end
      end
      tick();
    end
    check("sw8_drained", 64'(q8.size()), 64'd0);
    check("sw32_drained", 64'(q32.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised successor to the fixed 4-bit/12-bit ripple adders. WIDTH-bit add/subtract, split into SEG-bit ripple segments with one register stage per segment. This holds the carry path per cycle to SEG bits at one result per clock. Sits between operand producers and consumers using a valid/ready stream interface, and replaces hand-cascaded ripple_adder_twelve chains in wide datapaths.

Parameters:
WIDTH, 24, operand/result width; must be a multiple of SEG
SEG, 4, ripple segment width in bits (one pipeline stage per segment)
STAGES, WIDTH/SEG, derived pipeline depth; not overridable

Ports:
ck  input  1  clock, rising edge
rn  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block accepts operands this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
ci  input  1  carry-in (borrow-in when sub=1)
sub  input  1  0: A+B+ci; 1: A+~B+~ci
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
SUM  output  WIDTH  result
co  output  1  carry-out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR co

Behaviour:
- Reset (rn=0, async): every stage valid bit is 0. out_valid=0, SUM=0, co=0, ovf=0. All skew registers are 0. in_ready=1 from the first edge after release.
- Arithmetic: {co,SUM} = A + (B ^ {WIDTH{sub}}) + (ci ^ sub), computed modulo 2^(WIDTH+1).
  - sub=1, ci=0 gives A-B.
  - sub=1, ci=1 gives A-B-1.
- Stage k (0..STAGES-1) adds bits [k*SEG+SEG-1 : k*SEG] using the carry registered by stage k-1. Stage 0 uses ci^sub.
- Upper operand segments are delayed through input skew registers. Lower result segments are delayed through output deskew registers. SUM, co and ovf therefore appear coherently on one cycle.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - Transfer on input: in_valid && in_ready.
  - Transfer on output: out_valid && out_ready.
- Latency: a transfer accepted at edge t gives out_valid=1 after edge t+STAGES, provided adv stayed 1. With SEG=WIDTH this is a 1-cycle registered adder.
- Throughput: one result per cycle while out_ready=1. Bubbles (in_valid=0) propagate as invalid slots and do not stall.
- Stall (adv=0): all pipeline, skew and output registers hold. SUM/co/ovf stay stable while out_valid=1. No transfer is lost or duplicated.
- Data registers update only on adv, so outputs change only when a new result is presented. After reset, outputs read 0 until the first result.
- Simultaneous output transfer and new input in the same cycle is legal; the pipeline shifts by one.
- Reset mid-operation: all in-flight transfers are discarded. No out_valid appears for operands accepted before reset.
- ovf is meaningful for two's-complement operands in both modes. co is raw carry-out in both modes.
- Elaboration error if WIDTH % SEG != 0 or SEG < 1.

Test Plan:
1. Reset: assert rn=0 mid-clock with pipeline full. Required: out_valid=0, SUM=0, co=0, ovf=0 immediately (async). After release, in_ready=1 and no stale results emerge in the next 10 cycles.
2. Full carry ripple (WIDTH=24, SEG=4): A=0xFFFFFF, B=0x000001, ci=0, sub=0, out_ready=1. Required: out_valid exactly 6 cycles after accept, SUM=0x000000, co=1, ovf=0.
3. Carry-in chain: A=0x000FFF, B=0, ci=1, sub=0 gives SUM=0x001000, co=0. Then A=0x7FFFFF, B=1, ci=0 gives SUM=0x800000, co=0, ovf=1.
4. Subtract:
   - A=5, B=7, sub=1, ci=0 gives SUM=0xFFFFFE, co=0, ovf=0.
   - A=0x800000, B=1, sub=1 gives SUM=0x7FFFFF, co=1, ovf=1.
   - A=9, B=4, sub=1, ci=1 gives SUM=0x000004, co=1.
5. Streaming with backpressure: issue 8 back-to-back operand sets (A=i, B=0x100*i). Hold out_ready=0 for 3 cycles after the first out_valid. Required: in_ready=0 and outputs stable during the hold. All 8 results (SUM=0x101*i) appear in order, with none lost or duplicated.
6. Parameter sweep: SEG=WIDTH=8 (1 stage) and WIDTH=32, SEG=8 (4 stages). Run random operands against the reference model. Required: latency equals STAGES, and all results match {co,SUM} for 10k vectors.
